// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp
//   Multi-port integer register file with issue scoreboard for the pipelined
//   core. Two combinational read ports, two synchronous write ports (ALU on
//   port 0, LSU on port 1, port 1 wins on address collision), optional
//   same-cycle write-to-read forwarding, optional hard-wired zero register and
//   one busy bit per register (set at issue, cleared at writeback).
//
// Ports
//   clk, rst_n            clock, async active-low reset
//   rs1_addr, rs2_addr    read addresses
//   rs1_data, rs2_data    read data (combinational)
//   rs1_busy, rs2_busy    scoreboard bit of the read address (combinational)
//   we0/wa0/wd0           write port 0 (ALU writeback)
//   we1/wa1/wd1           write port 1 (LSU writeback)
//   iss_valid, iss_rd     issue of an instruction writing iss_rd
//   busy_any              OR of all registered busy bits
// ---------------------------------------------------------------------------
module regfile_mp #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREGS    = 32,
    parameter int unsigned AW       = $clog2(NREGS),
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            we0,
    input  logic [AW-1:0]   wa0,
    input  logic [XLEN-1:0] wd0,
    input  logic            we1,
    input  logic [AW-1:0]   wa1,
    input  logic [XLEN-1:0] wd1,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    output logic            busy_any
);

    localparam int unsigned NRP = 2;

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [NREGS-1:0] set_c;
    logic [NREGS-1:0] clr_c;

    logic [AW-1:0]    raddr_c [NRP];
    logic [XLEN-1:0]  rdata_c [NRP];
    logic             rbusy_c [NRP];

    // Per-register issue (set) and writeback (clear) decode
    always_comb begin
        set_c = '0;
        clr_c = '0;
        for (int unsigned r = 0; r < NREGS; r++) begin
            set_c[r] = iss_valid && (iss_rd == AW'(r));
            clr_c[r] = (we0 && (wa0 == AW'(r))) || (we1 && (wa1 == AW'(r)));
        end
        // Register 0 is never tracked when it is the hard-wired zero
        if (ZERO_REG != 0) begin
            set_c[0] = 1'b0;
        end
    end

    // Issue is younger than the writeback it coincides with, so set wins
    always_comb begin
        busy_d = (busy_q & ~clr_c) | set_c;
    end

    // Write-port merge; port 1 applied last so it wins a collision
    always_comb begin
        for (int unsigned r = 0; r < NREGS; r++) begin
            regs_d[r] = regs_q[r];
        end
        if (we0 && !((ZERO_REG != 0) && (wa0 == '0))) begin
            regs_d[wa0] = wd0;
        end
        if (we1 && !((ZERO_REG != 0) && (wa1 == '0))) begin
            regs_d[wa1] = wd1;
        end
    end

    // Storage and scoreboard state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                regs_q[r] <= regs_d[r];
            end
            busy_q <= busy_d;
        end
    end

    assign raddr_c[0] = rs1_addr;
    assign raddr_c[1] = rs2_addr;

    // Read ports: stored value, then forwarding (port 1 highest), then zero override
    always_comb begin
        for (int unsigned p = 0; p < NRP; p++) begin
            rdata_c[p] = regs_q[raddr_c[p]];
            rbusy_c[p] = busy_q[raddr_c[p]];
            if (BYPASS != 0) begin
                if (we0 && (wa0 == raddr_c[p])) begin
                    rdata_c[p] = wd0;
                end
                if (we1 && (wa1 == raddr_c[p])) begin
                    rdata_c[p] = wd1;
                end
                // A writeback this cycle resolves the hazard since data is forwarded
                rbusy_c[p] = busy_q[raddr_c[p]] && !clr_c[raddr_c[p]];
            end
            if ((ZERO_REG != 0) && (raddr_c[p] == '0)) begin
                rdata_c[p] = '0;
                rbusy_c[p] = 1'b0;
            end
        end
    end

    assign rs1_data = rdata_c[0];
    assign rs2_data = rdata_c[1];
    assign rs1_busy = rbusy_c[0];
    assign rs2_busy = rbusy_c[1];
    assign busy_any = |busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// ---------------------------------------------------------------------------
// tb_regfile_mp
//   Drives two register files from the same inputs: DUT a with the default
//   configuration (ZERO_REG=1, BYPASS=1) and DUT b with ZERO_REG=0, BYPASS=0.
//   Directed scenarios followed by randomized traffic, every output compared
//   against an array-based reference model of the architectural state.
// ---------------------------------------------------------------------------
module tb_regfile_mp;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;
    localparam int unsigned AW    = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [AW-1:0]   rs1_addr, rs2_addr, wa0, wa1, iss_rd;
    logic [XLEN-1:0] wd0, wd1;
    logic            we0, we1, iss_valid;

    logic [XLEN-1:0] a_rs1_data, a_rs2_data, b_rs1_data, b_rs2_data;
    logic            a_rs1_busy, a_rs2_busy, a_busy_any;
    logic            b_rs1_busy, b_rs2_busy, b_busy_any;

    int checks = 0;
    int errors = 0;

    // Reference model: index 0 mirrors DUT a, index 1 mirrors DUT b
    logic [XLEN-1:0] m_reg  [2][NREGS];
    logic            m_busy [2][NREGS];

    always #5 clk = ~clk;

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .ZERO_REG(1), .BYPASS(1)) u_a (
        .clk(clk), .rst_n(rst_n),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(a_rs1_data), .rs2_data(a_rs2_data),
        .rs1_busy(a_rs1_busy), .rs2_busy(a_rs2_busy),
        .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .busy_any(a_busy_any)
    );

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .ZERO_REG(0), .BYPASS(0)) u_b (
        .clk(clk), .rst_n(rst_n),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(b_rs1_data), .rs2_data(b_rs2_data),
        .rs1_busy(b_rs1_busy), .rs2_busy(b_rs2_busy),
        .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .busy_any(b_busy_any)
    );

    function automatic bit zr(input int d);
        return d == 0;
    endfunction

    function automatic bit bp(input int d);
        return d == 0;
    endfunction

    function automatic logic [XLEN-1:0] m_read(input int d, input logic [AW-1:0] a);
        if (zr(d) && a == 0) return '0;
        if (bp(d)) begin
            if (we1 && wa1 == a) return wd1;
            if (we0 && wa0 == a) return wd0;
        end
        return m_reg[d][a];
    endfunction

    function automatic logic m_rbusy(input int d, input logic [AW-1:0] a);
        logic wb;
        wb = (we0 && wa0 == a) || (we1 && wa1 == a);
        if (bp(d)) return m_busy[d][a] && !wb;
        return m_busy[d][a];
    endfunction

    function automatic logic m_any(input int d);
        logic any;
        any = 1'b0;
        for (int r = 0; r < NREGS; r++) any = any | m_busy[d][r];
        return any;
    endfunction

    task automatic m_reset();
        for (int d = 0; d < 2; d++)
            for (int r = 0; r < NREGS; r++) begin
                m_reg[d][r]  = '0;
                m_busy[d][r] = 1'b0;
            end
    endtask

    // Architectural effect of one rising edge
    task automatic m_clock();
        for (int d = 0; d < 2; d++) begin
            for (int r = 0; r < NREGS; r++) begin
                logic s, c;
                s = iss_valid && iss_rd == AW'(r) && !(zr(d) && r == 0);
                c = (we0 && wa0 == AW'(r)) || (we1 && wa1 == AW'(r));
                if (s) m_busy[d][r] = 1'b1;
                else if (c) m_busy[d][r] = 1'b0;
            end
            if (we0 && !(zr(d) && wa0 == 0)) m_reg[d][wa0] = wd0;
            if (we1 && !(zr(d) && wa1 == 0)) m_reg[d][wa1] = wd1;
        end
    endtask

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_a_rs1_data"}, a_rs1_data, m_read(0, rs1_addr));
        chk({tag, "_a_rs2_data"}, a_rs2_data, m_read(0, rs2_addr));
        chk({tag, "_a_rs1_busy"}, 32'(a_rs1_busy), 32'(m_rbusy(0, rs1_addr)));
        chk({tag, "_a_rs2_busy"}, 32'(a_rs2_busy), 32'(m_rbusy(0, rs2_addr)));
        chk({tag, "_a_busy_any"}, 32'(a_busy_any), 32'(m_any(0)));
        chk({tag, "_b_rs1_data"}, b_rs1_data, m_read(1, rs1_addr));
        chk({tag, "_b_rs2_data"}, b_rs2_data, m_read(1, rs2_addr));
        chk({tag, "_b_rs1_busy"}, 32'(b_rs1_busy), 32'(m_rbusy(1, rs1_addr)));
        chk({tag, "_b_rs2_busy"}, 32'(b_rs2_busy), 32'(m_rbusy(1, rs2_addr)));
        chk({tag, "_b_busy_any"}, 32'(b_busy_any), 32'(m_any(1)));
    endtask

    task automatic idle();
        we0 = 1'b0; we1 = 1'b0; iss_valid = 1'b0;
    endtask

    // Advance one clock; the model only sees edges where reset is released
    task automatic cyc();
        @(posedge clk);
        if (rst_n) m_clock();
        @(negedge clk);
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        if ($urandom_range(0, 1) == 1) return AW'($urandom_range(0, 3));
        return AW'($urandom_range(0, NREGS - 1));
    endfunction

    initial begin
        rst_n = 1'b0;
        rs1_addr = '0; rs2_addr = '0; wa0 = '0; wa1 = '0; iss_rd = '0;
        wd0 = '0; wd1 = '0;
        idle();
        m_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_all("init");
        chk("init_a_busy_any", 32'(a_busy_any), 32'h0);

        // 1: async reset clears stored data and scoreboard
        @(negedge clk);
        we0 = 1'b1; wa0 = 5; wd0 = 32'hDEADBEEF; iss_valid = 1'b1; iss_rd = 5;
        #1; check_all("t1_wr");
        cyc();
        idle(); rs1_addr = 5;
        #1; check_all("t1_held");
        chk("t1_a_r5", a_rs1_data, 32'hDEADBEEF);
        chk("t1_a_busy_any_set", 32'(a_busy_any), 32'h1);
        #1; rst_n = 1'b0;
        #1; m_reset();
        check_all("t1_rst");
        chk("t1_a_r5_rst", a_rs1_data, 32'h0);
        chk("t1_b_r5_rst", b_rs1_data, 32'h0);
        chk("t1_a_busy_any_rst", 32'(a_busy_any), 32'h0);
        // A write held across an edge inside reset must be dropped
        @(negedge clk);
        we0 = 1'b1; wa0 = 6; wd0 = 32'h1234; rs2_addr = 6;
        cyc();
        idle(); rst_n = 1'b1;
        #1; check_all("t1_nowr");
        chk("t1_b_r6_dropped", b_rs2_data, 32'h0);

        // 2: dual write collision, port 1 wins
        @(negedge clk);
        we0 = 1'b1; wa0 = 7; wd0 = 32'h11; we1 = 1'b1; wa1 = 7; wd1 = 32'h22; rs1_addr = 7;
        #1; check_all("t2_pre");
        chk("t2_a_fwd", a_rs1_data, 32'h22);
        cyc();
        idle();
        #1; check_all("t2_post");
        chk("t2_a_r7", a_rs1_data, 32'h22);
        chk("t2_b_r7", b_rs1_data, 32'h22);

        // 3: forwarding before the edge (a) vs. old value (b)
        @(negedge clk);
        rs1_addr = 3; we0 = 1'b1; wa0 = 3; wd0 = 32'hA5A5A5A5;
        #1; check_all("t3_pre");
        chk("t3_a_fwd", a_rs1_data, 32'hA5A5A5A5);
        chk("t3_b_old", b_rs1_data, 32'h0);
        cyc();
        idle();
        #1; check_all("t3_post");
        chk("t3_b_new", b_rs1_data, 32'hA5A5A5A5);

        // 4: register 0 hard-wired (a) vs. ordinary (b)
        @(negedge clk);
        rs1_addr = 0; we0 = 1'b1; wa0 = 0; wd0 = 32'hFFFFFFFF; iss_valid = 1'b1; iss_rd = 0;
        #1; check_all("t4_pre");
        cyc();
        idle();
        #1; check_all("t4_post");
        chk("t4_a_r0", a_rs1_data, 32'h0);
        chk("t4_a_r0_busy", 32'(a_rs1_busy), 32'h0);
        chk("t4_a_busy_any", 32'(a_busy_any), 32'h0);
        chk("t4_b_r0", b_rs1_data, 32'hFFFFFFFF);
        chk("t4_b_r0_busy", 32'(b_rs1_busy), 32'h1);

        // 5: scoreboard set, set-beats-clear, clear
        @(negedge clk);
        iss_valid = 1'b1; iss_rd = 9; rs2_addr = 9;
        cyc();
        idle();
        #1; check_all("t5_iss");
        chk("t5_a_busy", 32'(a_rs2_busy), 32'h1);
        @(negedge clk);
        we1 = 1'b1; wa1 = 9; wd1 = 32'h99; iss_valid = 1'b1; iss_rd = 9;
        #1; check_all("t5_both_pre");
        cyc();
        idle();
        #1; check_all("t5_both_post");
        chk("t5_a_still_busy", 32'(a_rs2_busy), 32'h1);
        chk("t5_b_still_busy", 32'(b_rs2_busy), 32'h1);
        @(negedge clk);
        we1 = 1'b1; wa1 = 9; wd1 = 32'h9A; we0 = 1'b1; wa0 = 0; wd0 = 32'h0;
        #1; check_all("t5_wb_pre");
        chk("t5_a_resolved", 32'(a_rs2_busy), 32'h0);
        chk("t5_b_not_yet", 32'(b_rs2_busy), 32'h1);
        cyc();
        idle();
        #1; check_all("t5_wb_post");
        chk("t5_a_clear", 32'(a_rs2_busy), 32'h0);
        chk("t5_b_clear", 32'(b_rs2_busy), 32'h0);
        chk("t5_a_any", 32'(a_busy_any), 32'h0);
        chk("t5_b_any", 32'(b_busy_any), 32'h0);

        // 6: randomized traffic with occasional asynchronous reset
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                idle();
                rst_n = 1'b0;
                #1; m_reset();
                check_all("rnd_rst");
                cyc();
                rst_n = 1'b1;
            end else begin
                rs1_addr  = rnd_addr();
                rs2_addr  = rnd_addr();
                we0       = 1'($urandom_range(0, 1));
                wa0       = rnd_addr();
                wd0       = $urandom;
                we1       = 1'($urandom_range(0, 1));
                wa1       = rnd_addr();
                wd1       = $urandom;
                iss_valid = 1'($urandom_range(0, 1));
                iss_rd    = rnd_addr();
                #1; check_all("rnd");
                cyc();
            end
        end

        idle();
        #1; check_all("final");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
